serial_subtractor_ctrl: RTL and testbench

//   Bit-serial N-bit subtractor controller: computes diff = a - b, LSB first,
//   one bit per clock, on a single full-subtractor bit cell built from two

---
 rtl/serial_subtractor_ctrl.sv | 167 ++++++++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor_ctrl
//  Description : Bit-serial N-bit subtractor (diff = a - b, LSB first) built
//                on one full-subtractor cell, with start/busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  Half-subtractor cell: d = x ^ y, borrow = ~x & y
// ----------------------------------------------------------------------------
module serial_subtractor_half (
    input  logic i_x,
    input  logic i_y,
    output logic o_d,
    output logic o_b
);
    assign o_d = i_x ^ i_y;
    assign o_b = ~i_x & i_y;
endmodule

// ----------------------------------------------------------------------------
//  Top-level controller
// ----------------------------------------------------------------------------
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out
);
    localparam int             CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res;
    logic [CNT_W-1:0] r_cnt;
    logic             r_brw;

    logic             w_accept;
    logic             w_last;
    logic             w_d1;
    logic             w_b1;
    logic             w_d;
    logic             w_b2;
    logic             w_brw_next;
    logic [WIDTH-1:0] w_res_next;

    // ------------------------------------------------------------------------
    //  Full-subtractor bit cell from two half-subtractors plus an OR
    // ------------------------------------------------------------------------
    serial_subtractor_half u_hs_ab (
        .i_x (r_a_sr[0]),
        .i_y (r_b_sr[0]),
        .o_d (w_d1),
        .o_b (w_b1)
    );

    serial_subtractor_half u_hs_brw (
        .i_x (w_d1),
        .i_y (r_brw),
        .o_d (w_d),
        .o_b (w_b2)
    );

    assign w_brw_next = w_b1 | w_b2;
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_last     = (r_state == S_SHIFT) && (r_cnt == c_LAST);

    // ------------------------------------------------------------------------
    //  FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    //  FSM next-state and handshake outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (r_cnt == c_LAST) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    //  Datapath: operand shift registers, borrow, counter, partial result
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr <= '0;
            r_b_sr <= '0;
            r_res  <= '0;
            r_cnt  <= '0;
            r_brw  <= 1'b0;
        end else if (w_accept) begin
            r_a_sr <= a_in;
            r_b_sr <= b_in;
            r_res  <= '0;
            r_cnt  <= '0;
            r_brw  <= 1'b0;
        end else if (r_state == S_SHIFT) begin
            r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
            r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
            r_res  <= w_res_next;
            r_brw  <= w_brw_next;
            if (!w_last) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Published result only changes on the final bit, so partial words never leak
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_out   <= '0;
            borrow_out <= 1'b0;
        end else if (w_last) begin
            diff_out   <= w_res_next;
            borrow_out <= w_brw_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor_ctrl
//  Description : Scoreboard-based self-checking bench for serial_subtractor_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor_ctrl;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff_out;
    logic             borrow_out;

    int tests;
    int fails;
    int done_cnt;

    logic [WIDTH:0] sb_q[$];
    logic [WIDTH:0] last_res;

    serial_subtractor_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a_in       (a_in),
        .b_in       (b_in),
        .busy       (busy),
        .done       (done),
        .diff_out   (diff_out),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [WIDTH:0] r;
        r = {1'b0, a} - {1'b0, b};
        return r;
    endfunction

    task automatic check(input string tag, input logic [WIDTH:0] obs,
                         input logic [WIDTH:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: pops on every done pulse, checks busy/done exclusivity
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy && done) check("busy_and_done", {7'd0, busy, done}, 9'd0);
            if (done) begin
                done_cnt++;
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 9'd1, 9'd0);
                end else begin
                    last_res = sb_q.pop_front();
                    check("result", {borrow_out, diff_out}, last_res);
                end
            end
        end
    end

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) check({tag, "_timeout"}, 9'd0, 9'd1);
    endtask

    // Drive one operation and check the cycle-accurate handshake timing
    task automatic run_op_timed(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] hold;
        hold = {borrow_out, diff_out};
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        sb_q.push_back(ref_sub(a, b));
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i == 0 || i == WIDTH - 1) begin
                check("busy_during_shift", {7'd0, busy, done}, 9'b10);
                check("result_held", {borrow_out, diff_out}, hold);
            end
            @(negedge clk);
        end
        check("done_latency", {7'd0, busy, done}, 9'b01);
        @(negedge clk);
        check("idle_after_done", {7'd0, busy, done}, 9'b00);
        check("result_hold", {borrow_out, diff_out}, ref_sub(a, b));
    endtask

    initial begin
        int base;
        int gap;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        tests    = 0;
        fails    = 0;
        done_cnt = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a_in     = '0;
        b_in     = '0;
        repeat (2) @(negedge clk);
        check("reset_state", {busy, done, borrow_out, diff_out[5:0]}, 9'd0);
        check("reset_diff", {1'b0, diff_out}, 9'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1. basic op and timing
        run_op_timed(8'h5A, 8'h3C);
        check("t1_value", {borrow_out, diff_out}, {1'b0, 8'h1E});

        // 2. boundary operand pairs
        run_op_timed(8'h00, 8'h01);
        check("t2_00_01", {borrow_out, diff_out}, {1'b1, 8'hFF});
        run_op_timed(8'h80, 8'h80);
        check("t2_80_80", {borrow_out, diff_out}, {1'b0, 8'h00});
        run_op_timed(8'hFF, 8'h00);
        check("t2_FF_00", {borrow_out, diff_out}, {1'b0, 8'hFF});
        run_op_timed(8'h00, 8'hFF);
        check("t2_00_FF", {borrow_out, diff_out}, {1'b1, 8'h01});

        // 3. start during SHIFT is ignored, operand change after accept ignored
        base = done_cnt;
        @(negedge clk);
        a_in  = 8'hC3;
        b_in  = 8'h5A;
        start = 1'b1;
        sb_q.push_back(ref_sub(8'hC3, 8'h5A));
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a_in  = 8'h11;
        b_in  = 8'h22;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t3");
        repeat (14) @(negedge clk);
        check("t3_single_done", 9'(done_cnt - base), 9'd1);
        check("t3_value", {borrow_out, diff_out}, {1'b0, 8'h69});

        // 4. start held high: one op per WIDTH+2 cycles
        @(negedge clk);
        a_in  = 8'h34;
        b_in  = 8'h12;
        start = 1'b1;
        sb_q.push_back(ref_sub(8'h34, 8'h12));
        wait_done("t4_first");
        for (int k = 0; k < 4; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            a_in = ra;
            b_in = rb;
            if (k == 3) start = 1'b0;
            else sb_q.push_back(ref_sub(ra, rb));
            if (k < 3) begin
                gap = 0;
                @(negedge clk);
                gap++;
                while (!done && gap < 40) begin
                    @(negedge clk);
                    gap++;
                end
                check("t4_done_spacing", 9'(gap), 9'(WIDTH + 2));
            end
        end
        repeat (14) @(negedge clk);
        check("t4_queue_drained", 9'(sb_q.size()), 9'd0);

        // 5. reset mid-operation aborts with no done
        @(negedge clk);
        a_in  = 8'hF0;
        b_in  = 8'h0F;
        start = 1'b1;
        sb_q.push_back(ref_sub(8'hF0, 8'h0F));
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        base  = done_cnt;
        rst_n = 1'b0;
        #1;
        check("t5_abort_ctrl", {7'd0, busy, done}, 9'd0);
        check("t5_abort_data", {borrow_out, diff_out}, 9'd0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("t5_no_done", 9'(done_cnt - base), 9'd0);
        run_op_timed(8'h0F, 8'hF0);
        check("t5_after_reset", {borrow_out, diff_out}, {1'b1, 8'h1F});

        // 6. random pairs against the reference model
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            a_in  = 8'($urandom);
            b_in  = 8'($urandom);
            start = 1'b1;
            sb_q.push_back(ref_sub(a_in, b_in));
            @(negedge clk);
            start = 1'b0;
            wait_done("t6");
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("t6_queue_drained", 9'(sb_q.size()), 9'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
